// File: rtl/piposr_pkg.sv
// piposr_pkg: state encoding and defaults shared by the shift-register frame sequencer.
package piposr_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/piposr_bitcnt.sv
// piposr_bitcnt: clear/enable bit counter with terminal count at WIDTH-1.
module piposr_bitcnt
    import piposr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end
    assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piposr_ctrl.sv
// piposr_ctrl: frame sequencer driving a PIPO shift register's din/ldin/ldout pins.
module piposr_ctrl
    import piposr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_ldin,
    output logic             sr_ldout,
    output logic             line_valid,
    output logic             rx_valid,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);
    logic [2:0] state;
    logic [2:0] state_nx;
    logic       tc;
    logic       accept;

    piposr_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk(CK),
        .rst(RST),
        .clr(state == S_LOAD),
        .en (state == S_SHIFT),
        .tc (tc)
    );

    assign tx_ready   = state == S_IDLE || state == S_DONE;
    assign accept     = tx_ready && tx_valid;
    assign sr_ldin    = state == S_LOAD;
    assign line_valid = state == S_SHIFT;
    assign sr_ldout   = state == S_CAPTURE;
    assign rx_valid   = state == S_DONE;
    assign busy       = state != S_IDLE;

    // DONE shares IDLE's accept path so back-to-back frames skip IDLE entirely
    always_comb begin
        state_nx = accept                ? S_LOAD    :
                   state == S_LOAD       ? S_SHIFT   :
                   state == S_SHIFT      ? (tc ? S_CAPTURE : S_SHIFT) :
                   state == S_CAPTURE    ? S_DONE    : S_IDLE;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_IDLE;
            sr_din    <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                sr_din <= tx_data;
            if (state == S_DONE)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_piposr_ctrl.sv
// tb_piposr_ctrl: randomized and directed frames checked against a frame-timing reference model.
module tb_piposr_ctrl;
    localparam int W = 4;

    logic         clk = 0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         si;
    logic         tx_ready, sr_ldin, sr_ldout, line_valid, rx_valid, busy;
    logic [W-1:0] sr_din;
    logic [7:0]   frame_cnt;
    logic         tx_ready2, sr_ldin2, sr_ldout2, line_valid2, rx_valid2, busy2;
    logic [W-1:0] sr_din2;
    logic [1:0]   frame_cnt2;
    logic [W-1:0] q, dout;
    logic         so;

    always #5 clk = ~clk;

    piposr_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
        .CK(clk), .RST(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .sr_din(sr_din), .sr_ldin(sr_ldin), .sr_ldout(sr_ldout),
        .line_valid(line_valid), .rx_valid(rx_valid), .busy(busy), .frame_cnt(frame_cnt)
    );

    piposr_ctrl #(.WIDTH(W), .CNT_W(2)) dut2 (
        .CK(clk), .RST(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready2), .sr_din(sr_din2), .sr_ldin(sr_ldin2), .sr_ldout(sr_ldout2),
        .line_valid(line_valid2), .rx_valid(rx_valid2), .busy(busy2), .frame_cnt(frame_cnt2)
    );

    // PIPO shift register: loads on ldin, otherwise shifts si in at the top, so out of bit0
    always @(posedge clk) begin
        if (sr_ldin)
            q <= sr_din;
        else
            q <= {si, q[W-1:1]};
        if (sr_ldout)
            dout <= q;
    end
    assign so = q[0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a frame accepted at cycle st occupies offsets 1 (load), 2..W+1 (shift), W+2 (capture), W+3 (done)
    bit           act = 0;
    int           st = 0;
    int           cyc = 0;
    int           cnt = 0;
    int           nacc = 0;
    logic [W-1:0] w = '0, rxw = '0, sw = '0, dexp = '0;
    logic [W-1:0] si_force = '0;
    bit           use_force = 0;

    task automatic tick(input logic v, input logic [W-1:0] d, input logic r);
        int   o;
        logic rdy;
        @(negedge clk);
        o   = act ? cyc - st : 0;
        rdy = !act || o == W + 3;
        check("tx_ready", tx_ready, rdy);
        check("busy", busy, act);
        check("sr_ldin", sr_ldin, o == 1);
        check("line_valid", line_valid, o >= 2 && o <= W + 1);
        check("sr_ldout", sr_ldout, o == W + 2);
        check("rx_valid", rx_valid, o == W + 3);
        check("frame_cnt", frame_cnt, cnt % 256);
        check("frame_cnt_w2", frame_cnt2, cnt % 4);
        check("sr_din", sr_din, dexp);
        if (o >= 2 && o <= W + 1)
            check("so", so, w[o-2]);
        if (o == W + 3)
            check("dout", dout, rxw);
        tx_valid = v;
        tx_data  = d;
        rst      = r;
        si       = (o >= 2 && o <= W + 1) ? sw[o-2] : 1'($urandom_range(0, 1));
        @(posedge clk);
        if (o >= 2 && o <= W + 1)
            rxw[o-2] = si;
        if (act && o == W + 3) begin
            cnt++;
            act = 0;
        end
        if (r) begin
            act  = 0;
            cnt  = 0;
            dexp = '0;
        end else if (v && rdy) begin
            act  = 1;
            st   = cyc;
            w    = d;
            dexp = d;
            sw   = use_force ? si_force : W'($urandom);
            nacc++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(0, W'($urandom), 0);
    endtask

    logic [W-1:0] burst [3] = '{4'hA, 4'h5, 4'hF};

    initial begin
        int base;
        int guard;
        rst = 1; tx_valid = 0; tx_data = '0; si = 0;
        repeat (2) @(posedge clk);
        tick(0, '0, 1);
        idle(5);
        use_force = 1;
        si_force  = 4'b1001;
        tick(1, 4'b1011, 0);
        idle(10);
        use_force = 0;
        base  = nacc;
        guard = 0;
        while (nacc - base < 3 && guard < 40) begin
            tick(1, burst[nacc-base], 0);
            guard++;
        end
        check("burst_accepts", nacc - base, 3);
        check("burst_cycles", guard, 15);
        idle(10);
        tick(0, '0, 1);
        idle(3);
        tick(1, 4'h6, 0);
        tick(0, '0, 0);
        tick(0, '0, 0);
        tick(0, '0, 1);
        idle(4);
        tick(1, 4'h9, 0);
        idle(10);
        tick(1, 4'h3, 0);
        tick(0, '0, 0);
        tick(1, 4'hC, 0);
        tick(0, '0, 0);
        idle(10);
        for (int i = 0; i < 600; i++)
            tick(1'($urandom_range(0, 2) != 0), W'($urandom), $urandom_range(0, 59) == 0);
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
